// File: rtl/icestick_pkg.sv
// Board-level constants for the icestick SoC core clock and IrDA SIR line rate.
package icestick_pkg;

  localparam int CLK_CORE_HZ = 39_750_000;
  localparam int SIR_BAUD    = 9600;

  // Rounded clock cycles per bit period at a given baud rate.
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/irda_pulse_qual.sv
// Synchronises the raw IrDA RXD pad and emits a one-cycle strobe for each
// low pulse that lasts at least MIN_PULSE core cycles.
module irda_pulse_qual #(
  parameter int MIN_PULSE = 32
) (
  input  logic clk_core,
  input  logic reset_n,
  input  logic irda_rxd,
  output logic pulse_strobe
);

  localparam int CW = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_PULSE);
  localparam logic [CW-1:0] CNT_FIRE = CW'(MIN_PULSE - 1);

  logic          rxd_meta;
  logic          rxd_sync;
  logic [CW-1:0] low_cnt;

  // Counter saturates at MIN_PULSE so a long low run strobes only once.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta     <= 1'b1;
      rxd_sync     <= 1'b1;
      low_cnt      <= '0;
      pulse_strobe <= 1'b0;
    end else begin
      rxd_meta     <= irda_rxd;
      rxd_sync     <= rxd_meta;
      pulse_strobe <= 1'b0;
      if (rxd_sync) begin
        low_cnt <= '0;
      end else if (low_cnt != CNT_MAX) begin
        low_cnt      <= low_cnt + 1'b1;
        pulse_strobe <= (low_cnt == CNT_FIRE);
      end
    end
  end

endmodule

// File: rtl/irda_sir_rx.sv
// IrDA SIR receive demodulator: qualified pulses -> bytes on a valid/ready
// output register with sticky framing-error and overrun flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a qualified start pulse
//   DATA    | sampling 8 data windows, LSB first, pulse = 0 bit
//   STOP    | stop window; a pulse here is a framing error
module irda_sir_rx
  import icestick_pkg::*;
#(
  parameter int BIT_CYCLES = cycles_per_bit(CLK_CORE_HZ, SIR_BAUD),
  parameter int MIN_PULSE  = 32,
  parameter int LEAD       = BIT_CYCLES / 4
) (
  input  logic       clk_core,
  input  logic       reset_n,
  input  logic       irda_rxd,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clear
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam int TW = $clog2(BIT_CYCLES + LEAD);
  // Start strobe arrives MIN_PULSE into the start bit; the first window
  // runs on past the next nominal bit start by LEAD.
  localparam logic [TW-1:0] START_LOAD = TW'(BIT_CYCLES - MIN_PULSE + LEAD);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_CYCLES - 1);

  logic          pulse_strobe;
  logic [1:0]    state;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic          pulse_seen;
  logic [7:0]    shift_reg;
  logic          window_end;
  logic          pulse_now;
  logic          stop_end;
  logic          byte_good;
  logic          frame_bad;

  irda_pulse_qual #(.MIN_PULSE(MIN_PULSE)) u_pulse_qual (
    .clk_core     (clk_core),
    .reset_n      (reset_n),
    .irda_rxd     (irda_rxd),
    .pulse_strobe (pulse_strobe)
  );

  always_comb begin
    window_end = (bit_timer == '0);
    pulse_now  = pulse_seen | pulse_strobe;
    stop_end   = rx_enable && (state == ST_STOP) && window_end;
    byte_good  = stop_end && !pulse_now;
    frame_bad  = stop_end && pulse_now;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      pulse_seen <= 1'b0;
      shift_reg  <= '0;
    end else if (!rx_enable) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      pulse_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pulse_strobe) begin
            state      <= ST_DATA;
            bit_timer  <= START_LOAD;
            bit_idx    <= '0;
            pulse_seen <= 1'b0;
          end
        end
        ST_DATA: begin
          if (window_end) begin
            shift_reg  <= {~pulse_now, shift_reg[7:1]};
            pulse_seen <= 1'b0;
            bit_timer  <= BIT_LOAD;
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_timer  <= bit_timer - 1'b1;
            pulse_seen <= pulse_now;
          end
        end
        ST_STOP: begin
          if (window_end) begin
            state      <= ST_IDLE;
            pulse_seen <= 1'b0;
          end else begin
            bit_timer  <= bit_timer - 1'b1;
            pulse_seen <= pulse_now;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A same-cycle handshake frees the slot, so an arriving byte is no overrun.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (byte_good) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (byte_good && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (err_clear)                     overrun <= 1'b0;
      if (frame_bad)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irda_sir_rx.sv
// Directed bench for irda_sir_rx with a shortened bit period.
module tb_irda_sir_rx;

  localparam int BITC   = 200;
  localparam int MINP   = 8;
  localparam int LEADC  = 50;
  localparam int PULSE  = 12;
  localparam int GLITCH = 5;

  logic       clk_core  = 1'b0;
  logic       reset_n   = 1'b1;
  logic       irda_rxd  = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rx_ready  = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         vcnt    = 0;
  int         v0      = 0;
  logic [7:0] last_data = 8'h00;

  always #5 clk_core = ~clk_core;

  irda_sir_rx #(.BIT_CYCLES(BITC), .MIN_PULSE(MINP), .LEAD(LEADC)) dut (
    .clk_core  (clk_core),
    .reset_n   (reset_n),
    .irda_rxd  (irda_rxd),
    .rx_enable (rx_enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clear (err_clear)
  );

  // Counts cycles with rx_valid high and remembers the last byte seen.
  always @(negedge clk_core) begin
    if (rx_valid) begin
      vcnt      <= vcnt + 1;
      last_data <= rx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    irda_rxd = v;
    repeat (n) @(negedge clk_core);
  endtask

  // Frame index 0 = start, 1..8 = data LSB first, 9 = stop; 0 = pulse.
  task automatic send_frame(input logic [7:0] b, input int blen, input bit stop_pulse,
                            input bit glitch, input int drop_at, input int nbits);
    logic [9:0] frame;
    int plen;
    frame = {~stop_pulse, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      if (k == drop_at) rx_enable = 1'b0;
      plen = frame[k] ? 0 : PULSE;
      if (plen > 0) line(1'b0, plen);
      if (glitch && k >= 1 && k <= 8) begin
        line(1'b1, blen / 2 - plen);
        line(1'b0, GLITCH);
        line(1'b1, blen - blen / 2 - GLITCH);
      end else begin
        line(1'b1, blen - plen);
      end
    end
    irda_rxd = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_core);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    reset_n   = 1'b1;
    rx_enable = 1'b1;
    rx_ready  = 1'b1;
    line(1'b1, 20);

    // 0x55 with consumer always ready
    v0 = vcnt;
    send_frame(8'h55, BITC, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("b55_valid_cycles", vcnt - v0, 1);
    check("b55_data", last_data, 8'h55);
    check("b55_valid_now", rx_valid, 1'b0);
    check("b55_ferr", frame_err, 1'b0);
    check("b55_ovr", overrun, 1'b0);

    // 0x00 then 0xFF with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h00, BITC, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("b00_valid", rx_valid, 1'b1);
    check("b00_data", rx_data, 8'h00);
    check("b00_ovr", overrun, 1'b0);
    send_frame(8'hFF, BITC, 1'b0, 1'b0, -1, 10);
    line(1'b1, 50);
    check("bff_data", rx_data, 8'hFF);
    check("bff_ovr", overrun, 1'b1);
    check("bff_valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    @(negedge clk_core);
    rx_ready = 1'b0;
    check("bff_valid_consumed", rx_valid, 1'b0);
    check("bff_ovr_sticky", overrun, 1'b1);
    err_clear = 1'b1;
    @(negedge clk_core);
    err_clear = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    rx_ready = 1'b1;

    // Idle glitch must not start a frame
    line(1'b0, GLITCH);
    v0 = vcnt;
    line(1'b1, 11 * BITC);
    check("idle_glitch_no_byte", vcnt - v0, 0);
    check("idle_glitch_ferr", frame_err, 1'b0);

    // 0xA3 with a short glitch in the middle of every data bit
    v0 = vcnt;
    send_frame(8'hA3, BITC, 1'b0, 1'b1, -1, 10);
    line(1'b1, 20);
    check("ba3_valid_cycles", vcnt - v0, 1);
    check("ba3_data", last_data, 8'hA3);
    check("ba3_ferr", frame_err, 1'b0);

    // 0x12 with a pulse in the stop window
    v0 = vcnt;
    send_frame(8'h12, BITC, 1'b1, 1'b0, -1, 10);
    line(1'b1, 20);
    check("b12_ferr", frame_err, 1'b1);
    check("b12_no_byte", vcnt - v0, 0);
    check("b12_valid", rx_valid, 1'b0);
    err_clear = 1'b1;
    @(negedge clk_core);
    err_clear = 1'b0;
    check("ferr_cleared", frame_err, 1'b0);

    // 0x3C aborted by rx_enable at data bit 4, then 0xC3 held for the consumer
    rx_ready = 1'b0;
    send_frame(8'h3C, BITC, 1'b0, 1'b0, 5, 10);
    line(1'b1, 20);
    check("b3c_discarded", rx_valid, 1'b0);
    rx_enable = 1'b1;
    line(1'b1, 20);
    send_frame(8'hC3, BITC, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("bc3_valid", rx_valid, 1'b1);
    check("bc3_data", rx_data, 8'hC3);
    check("bc3_ovr", overrun, 1'b0);

    // Asynchronous reset in the middle of 0x81
    send_frame(8'h81, BITC, 1'b0, 1'b0, -1, 4);
    @(posedge clk_core);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", rx_valid, 1'b0);
    check("arst_data", rx_data, 8'h00);
    irda_rxd = 1'b1;
    repeat (3) @(negedge clk_core);
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    line(1'b1, 20);
    v0 = vcnt;
    send_frame(8'h81, BITC, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("b81_valid_cycles", vcnt - v0, 1);
    check("b81_data", last_data, 8'h81);

    // 0xE7 at +2% and -2% bit rate
    v0 = vcnt;
    send_frame(8'hE7, BITC + BITC / 50, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("be7_slow_cycles", vcnt - v0, 1);
    check("be7_slow_data", last_data, 8'hE7);
    v0 = vcnt;
    send_frame(8'hE7, BITC - BITC / 50, 1'b0, 1'b0, -1, 10);
    line(1'b1, 20);
    check("be7_fast_cycles", vcnt - v0, 1);
    check("be7_fast_data", last_data, 8'hE7);
    check("final_ferr", frame_err, 1'b0);
    check("final_ovr", overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
